wb_camara: RTL and testbench
============================

# wb_camara

Camera capture engine, the input-side counterpart of the Wishbone display path. It samples an 8-bit parallel camera bus (PCLK/VSYNC/HREF, two bytes per RGB444 pixel) in the system clock domain and packs each pixel into one 32-bit word. As a Wishbone initiator, it writes each word to memory at consecutive addresses from a programmable base. A Wishbone responder register bank provides start/continuous control, base address, status and counters.

## Interface
- MAX_PIXELS, 19200, pixels stored per frame (160x120); index width = clog2(MAX_PIXELS+1)
- FIFO_DEPTH, 4, pixel words buffered between capture and bus master (power of two)
- clk  in  1  system clock; cam_pclk must satisfy f_pclk <= f_clk/4
- reset  in  1  synchronous, active-high
- wb_stb_i, wb_cyc_i, wb_we_i  in  1 each  responder strobe/cycle/write
- wb_adr_i  in  32  responder address; decode on [4:0]
- wb_sel_i  in  4  ignored; full-word accesses only
- wb_dat_i  in  32  responder write data
- wb_ack_o  out  1  responder ack
- wb_dat_o  out  32  responder read data
- m_cyc_o, m_stb_o, m_we_o  out  1 each  initiator cycle/strobe/write
- m_adr_o  out  32  initiator byte address
- m_sel_o  out  4  always 4'b1111 during a cycle
- m_dat_o  out  32  {20'b0, R[3:0], G[3:0], B[3:0]}
- m_ack_i  in  1  initiator ack from memory
- cam_pclk, cam_vsync, cam_href  in  1 each  camera async inputs
- cam_data  in  8  camera byte

## Operation
- Registers: 0x00 CTRL (W: bit0 start one-shot, self-clearing; bit1 cont; R: {30'b0, cont, 1'b0}). 0x04 BASE (R/W, [1:0] forced 0). 0x08 STATUS (R: bit0 busy, bit1 done, bit2 ovf; W1C on bits 1,2). 0x0C PIXCNT (R, pixels stored in current/last frame). 0x10 FRMCNT (R, frames completed, 16-bit, wraps). Other offsets read 0, writes ignored.
- Inputs pass a 2-FF synchronizer. Events come from the synced value vs. a third delayed copy: pclk_rise, vsync_rise, vsync_fall.
- Capture FSM states: IDLE, WAIT_FRAME, CAPTURE, FLUSH.
  - IDLE -> WAIT_FRAME on start while not busy. Clears PIXCNT and done; loads write address from BASE. start while busy is ignored.
  - WAIT_FRAME -> CAPTURE on vsync_fall (frame start).
  - CAPTURE: on pclk_rise with href high, the byte toggle selects the byte. Byte0 latches R = data[3:0]. Byte1 forms the pixel from G = data[7:4], B = data[3:0], pushed to the FIFO. The toggle resets to byte0 while href is low.
  - CAPTURE -> FLUSH on vsync_rise.
  - FLUSH -> when the FIFO is empty and the master is idle: set done, increment FRMCNT, then go to WAIT_FRAME if cont=1, else IDLE.
- busy = 1 in WAIT_FRAME, CAPTURE and FLUSH.
- Pixels are dropped and ovf is set when either of these holds:
  - PIXCNT == MAX_PIXELS, in which case PIXCNT saturates;
  - the FIFO is full at push time.
- Master: when idle and the FIFO is non-empty, pop a word and assert cyc/stb/we with adr = BASE_latched + 4*index. Hold all master outputs stable until m_ack_i. On ack, deassert cyc/stb the next cycle and increment PIXCNT. At most one outstanding transfer; no back-to-back in the ack cycle.
- Writing cont=0 mid-frame: the current frame completes, then the FSM returns to IDLE.

## Timing
- Responder: ack rises one cycle after stb & cyc & ~ack, lasts one cycle, and is gated by stb & cyc. Read data is registered and valid with ack. Register writes take effect on the ack edge.
- Camera-to-FIFO latency: 3 clk cycles from the cam_pclk edge carrying byte1 to the FIFO push.
- FIFO-to-bus latency: m_stb_o asserts 1 cycle after a non-empty FIFO is observed with the master idle.
- Simultaneous FIFO push and pop: allowed; count unchanged.
- Simultaneous STATUS W1C and a hardware set of the same bit: the set wins.
- Reset values: wb_ack_o 0, wb_dat_o 0, m_cyc_o/m_stb_o/m_we_o 0, m_adr_o 0, m_dat_o 0, m_sel_o 0, CTRL 0, BASE 0, STATUS 0, PIXCNT 0, FRMCNT 0, FSM IDLE, FIFO empty.
- Reset during a transfer drops m_cyc_o the following cycle. An in-flight ack after reset is ignored.

## Test plan
- Reset, then read all registers → all 0. Write BASE=0x1003, read → 0x1000.
- BASE=0x2000, start, then a 2-line x 3-pixel frame, bytes (0x0A,0x5C) per pixel, memory acks after 0 wait states → six writes of 0x00000A5C to 0x2000..0x2014; STATUS=0x2; PIXCNT=6; FRMCNT=1.
- Memory acks after 10 wait states with pclk at clk/4 → FIFO fills, ovf set, PIXCNT < pixels sent, m_adr_o/m_dat_o stable throughout each stall.
- MAX_PIXELS=4 and a 6-pixel frame → exactly 4 writes, PIXCNT=4, ovf=1. Writing STATUS=0x6 → STATUS reads 0.
- CTRL=0x3, capture 3 frames, write CTRL=0 during frame 3 → FRMCNT=3, then IDLE (busy=0); addresses restart at BASE each frame.
- Assert reset mid-CAPTURE with m_stb_o high → next cycle cyc/stb=0, busy=0. A later start captures normally from BASE.

Source files
------------

// File: rtl/wb_camara.sv
// rtl/wb_camara.sv - Wishbone camera capture engine (RGB444 pixels to memory)
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   wb_*_i / wb_*_o        Wishbone responder: CTRL, BASE, STATUS, PIXCNT, FRMCNT
//   m_*_o / m_ack_i        Wishbone initiator: one 32-bit write per captured pixel
//   cam_pclk, cam_vsync,   asynchronous camera bus, two bytes per pixel
//   cam_href, cam_data
module wb_camara #(
  parameter int MAX_PIXELS = 19200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [31:0] m_adr_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_dat_o,
  input  logic        m_ack_i,
  input  logic        cam_pclk,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data
);

  localparam int IW = $clog2(MAX_PIXELS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, FLUSH} state_t;
  state_t state, state_nxt;

  // Camera synchronizers: stages [1:0] are the 2-FF synchronizer, stage [2]
  // is the delayed copy used for edge detection.
  logic [2:0] pclk_sy, vsync_sy;
  logic [1:0] href_sy;
  logic [7:0] data_s1, data_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      pclk_sy  <= '0;
      vsync_sy <= '0;
      href_sy  <= '0;
      data_s1  <= '0;
      data_s2  <= '0;
    end else begin
      pclk_sy  <= {pclk_sy[1:0], cam_pclk};
      vsync_sy <= {vsync_sy[1:0], cam_vsync};
      href_sy  <= {href_sy[0], cam_href};
      data_s1  <= cam_data;
      data_s2  <= data_s1;
    end
  end

  logic pclk_rise, vsync_rise, vsync_fall, href_s;
  assign pclk_rise  = pclk_sy[1] & ~pclk_sy[2];
  assign vsync_rise = vsync_sy[1] & ~vsync_sy[2];
  assign vsync_fall = ~vsync_sy[1] & vsync_sy[2];
  assign href_s     = href_sy[1];

  // Register bank state
  logic          cont_r, done_r, ovf_r;
  logic [31:0]   base_r, wr_base;
  logic [IW-1:0] pixcnt, accepted;
  logic [15:0]   frmcnt;
  logic          busy;

  logic       reg_access, reg_wr, start, status_wr;
  logic [4:0] reg_off;
  logic [31:0] rd_data;

  assign reg_access = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign reg_wr     = reg_access & wb_we_i;
  assign reg_off    = wb_adr_i[4:0];
  assign start      = reg_wr && (reg_off == 5'h00) && wb_dat_i[0];
  assign status_wr  = reg_wr && (reg_off == 5'h08);
  assign busy       = (state != IDLE);

  logic unused_inputs;
  assign unused_inputs = ^{wb_sel_i, wb_adr_i[31:5]};

  always_comb begin
    rd_data = '0;
    case (reg_off)
      5'h00:   rd_data = {30'b0, cont_r, 1'b0};
      5'h04:   rd_data = base_r;
      5'h08:   rd_data = {29'b0, ovf_r, done_r, busy};
      5'h0C:   rd_data = 32'(pixcnt);
      5'h10:   rd_data = {16'b0, frmcnt};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= reg_access;
      if (reg_access && !wb_we_i) wb_dat_o <= rd_data;
    end
  end

  // FIFO between capture and bus master
  logic [11:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   fcount;
  logic          fifo_full, fifo_empty, push, pop, drop;
  logic [11:0]   push_word;

  assign fifo_full  = (fcount == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (fcount == '0);

  // Capture: byte toggle selects R byte vs G/B byte
  logic       byte_sel;
  logic [3:0] r_lat;
  logic       pix_valid, pix_limit;

  assign pix_valid = (state == CAPTURE) && pclk_rise && href_s && byte_sel;
  // Limit is judged on pixels accepted into the frame, so pixels already
  // queued or in flight count against MAX_PIXELS.
  assign pix_limit = (accepted == IW'(MAX_PIXELS));
  assign push      = pix_valid && !fifo_full && !pix_limit;
  assign drop      = pix_valid && (fifo_full || pix_limit);
  assign push_word = {r_lat, data_s2[7:4], data_s2[3:0]};
  assign pop       = !m_cyc_o && !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset || state != CAPTURE || !href_s) begin
      byte_sel <= 1'b0;
      if (reset) r_lat <= '0;
    end else if (pclk_rise) begin
      if (!byte_sel) r_lat <= data_s2[3:0];
      byte_sel <= ~byte_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr   <= '0;
      rptr   <= '0;
      fcount <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   fcount <= fcount + 1'b1;
        2'b01:   fcount <= fcount - 1'b1;
        default: fcount <= fcount;
      endcase
    end
  end

  // Bus master: single outstanding write, outputs held until ack
  always_ff @(posedge clk) begin
    if (reset) begin
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
      m_we_o  <= 1'b0;
      m_sel_o <= '0;
      m_adr_o <= '0;
      m_dat_o <= '0;
    end else if (m_cyc_o) begin
      if (m_ack_i) begin
        m_cyc_o <= 1'b0;
        m_stb_o <= 1'b0;
        m_we_o  <= 1'b0;
        m_sel_o <= '0;
      end
    end else if (pop) begin
      m_cyc_o <= 1'b1;
      m_stb_o <= 1'b1;
      m_we_o  <= 1'b1;
      m_sel_o <= 4'b1111;
      m_adr_o <= wr_base + (32'(pixcnt) << 2);
      m_dat_o <= {20'b0, fifo_mem[rptr]};
    end
  end

  // Capture FSM
  logic frame_end;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    frame_end = 1'b0;
    case (state)
      IDLE:       if (start) state_nxt = WAIT_FRAME;
      WAIT_FRAME: if (vsync_fall) state_nxt = CAPTURE;
      CAPTURE:    if (vsync_rise) state_nxt = FLUSH;
      FLUSH: begin
        if (fifo_empty && !m_cyc_o) begin
          frame_end = 1'b1;
          state_nxt = cont_r ? WAIT_FRAME : IDLE;
        end
      end
      default:    state_nxt = IDLE;
    endcase
  end

  // Registers and counters. Hardware sets come after the W1C clears so a
  // simultaneous set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      cont_r   <= 1'b0;
      base_r   <= '0;
      wr_base  <= '0;
      done_r   <= 1'b0;
      ovf_r    <= 1'b0;
      pixcnt   <= '0;
      accepted <= '0;
      frmcnt   <= '0;
    end else begin
      if (reg_wr && reg_off == 5'h00) cont_r <= wb_dat_i[1];
      if (reg_wr && reg_off == 5'h04) base_r <= {wb_dat_i[31:2], 2'b00};
      if (status_wr) begin
        if (wb_dat_i[1]) done_r <= 1'b0;
        if (wb_dat_i[2]) ovf_r  <= 1'b0;
      end
      if (state == IDLE && start) begin
        pixcnt   <= '0;
        accepted <= '0;
        done_r   <= 1'b0;
        wr_base  <= base_r;
      end
      // Each frame writes from the base again
      if (state == WAIT_FRAME && vsync_fall) begin
        pixcnt   <= '0;
        accepted <= '0;
      end
      if (push) accepted <= accepted + 1'b1;
      if (m_cyc_o && m_ack_i && pixcnt != IW'(MAX_PIXELS)) pixcnt <= pixcnt + 1'b1;
      if (drop) ovf_r <= 1'b1;
      if (frame_end) begin
        done_r <= 1'b1;
        frmcnt <= frmcnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_camara.sv
// tb/tb_wb_camara.sv - directed bench for wb_camara
module tb_wb_camara;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        wb_stb, wb_cyc, wb_we;
  logic [31:0] wb_adr, wb_wdat;
  logic        use_small;
  logic        cam_pclk, cam_vsync, cam_href;
  logic [7:0]  cam_data;
  logic        mem_ack = 1'b0;

  logic        ack0, ack1, mc0, mc1, ms0, ms1, mw0, mw1;
  logic [31:0] rd0, rd1, ma0, ma1, md0, md1;
  logic [3:0]  msel0, msel1;

  // Big instance uses the full frame size, small one checks the pixel limit.
  wb_camara #(.MAX_PIXELS(19200), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc & ~use_small), .wb_we_i(wb_we),
    .wb_adr_i(wb_adr), .wb_sel_i(4'hF), .wb_dat_i(wb_wdat),
    .wb_ack_o(ack0), .wb_dat_o(rd0),
    .m_cyc_o(mc0), .m_stb_o(ms0), .m_we_o(mw0), .m_adr_o(ma0), .m_sel_o(msel0),
    .m_dat_o(md0), .m_ack_i(mem_ack & ~use_small),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data)
  );

  wb_camara #(.MAX_PIXELS(4), .FIFO_DEPTH(4)) dut_small (
    .clk(clk), .reset(reset),
    .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc & use_small), .wb_we_i(wb_we),
    .wb_adr_i(wb_adr), .wb_sel_i(4'hF), .wb_dat_i(wb_wdat),
    .wb_ack_o(ack1), .wb_dat_o(rd1),
    .m_cyc_o(mc1), .m_stb_o(ms1), .m_we_o(mw1), .m_adr_o(ma1), .m_sel_o(msel1),
    .m_dat_o(md1), .m_ack_i(mem_ack & use_small),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data)
  );

  logic        wb_ack, m_cyc, m_stb;
  logic [31:0] wb_rdat, m_adr, m_dat;
  logic [3:0]  m_sel;
  assign wb_ack  = use_small ? ack1 : ack0;
  assign wb_rdat = use_small ? rd1 : rd0;
  assign m_cyc   = use_small ? mc1 : mc0;
  assign m_stb   = use_small ? ms1 : ms0;
  assign m_adr   = use_small ? ma1 : ma0;
  assign m_dat   = use_small ? md1 : md0;
  assign m_sel   = use_small ? msel1 : msel0;

  int checks = 0;
  int errors = 0;

  // Memory model: acks after wait_states stall cycles, logs each write and
  // counts any change of address/data while a transfer is stalled.
  int          wait_states = 0;
  int          wcnt = 0;
  int          nlog = 0;
  int          stall_err = 0;
  logic        in_stall = 1'b0;
  logic [31:0] prev_adr, prev_dat;
  logic [31:0] log_adr [256];
  logic [31:0] log_dat [256];

  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack  <= 1'b0;
      in_stall <= 1'b0;
    end else if (m_cyc && m_stb) begin
      if (in_stall && (m_adr !== prev_adr || m_dat !== prev_dat)) stall_err <= stall_err + 1;
      prev_adr <= m_adr;
      prev_dat <= m_dat;
      in_stall <= 1'b1;
      if (wcnt >= wait_states) begin
        mem_ack <= 1'b1;
        wcnt    <= 0;
        in_stall <= 1'b0;
        log_adr[nlog % 256] <= m_adr;
        log_dat[nlog % 256] <= m_dat;
        nlog <= nlog + 1;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt     <= 0;
      in_stall <= 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    int t;
    t = 0;
    wb_adr = a; wb_wdat = d; wb_we = 1'b1; wb_stb = 1'b1; wb_cyc = 1'b1;
    do begin @(negedge clk); t++; end while (!wb_ack && t < 20);
    if (!wb_ack) begin
      checks++; errors++;
      $display("FAIL wb_write_ack adr=%h: no ack within 20 cycles", a);
    end
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    int t;
    t = 0;
    wb_adr = a; wb_we = 1'b0; wb_stb = 1'b1; wb_cyc = 1'b1;
    do begin @(negedge clk); t++; end while (!wb_ack && t < 20);
    if (!wb_ack) begin
      checks++; errors++;
      $display("FAIL wb_read_ack adr=%h: no ack within 20 cycles", a);
    end
    d = wb_rdat;
    wb_stb = 1'b0; wb_cyc = 1'b0;
    @(negedge clk);
  endtask

  task automatic cam_byte(input logic [7:0] b);
    cam_data = b;
    tick(2);
    cam_pclk = 1'b1;
    tick(2);
    cam_pclk = 1'b0;
  endtask

  // vsync falls to open the frame and rises to close it
  task automatic cam_frame(input int lines, input int px, input logic [7:0] b0, input logic [7:0] b1);
    cam_vsync = 1'b0;
    tick(8);
    for (int l = 0; l < lines; l++) begin
      cam_href = 1'b1;
      tick(2);
      for (int p = 0; p < px; p++) begin
        cam_byte(b0);
        cam_byte(b1);
      end
      tick(2);
      cam_href = 1'b0;
      tick(8);
    end
    cam_vsync = 1'b1;
    tick(8);
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] d;
    int t;
    t = 0;
    d = 32'h1;
    while (d[0] && t < budget) begin
      wb_read(32'h08, d);
      t++;
    end
    if (d[0]) begin
      checks++; errors++;
      $display("FAIL wait_idle: busy still %0d after %0d polls", d[0], budget);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] offs [6];
    offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};
    apply_reset();
    checks++; if (m_cyc !== 1'b0 || m_stb !== 1'b0) begin errors++; $display("FAIL rst_m_cyc_stb: got %b%b expected 00", m_cyc, m_stb); end
    checks++; if (m_sel !== 4'h0) begin errors++; $display("FAIL rst_m_sel: got %h expected 0", m_sel); end
    checks++; if (m_adr !== 32'h0 || m_dat !== 32'h0) begin errors++; $display("FAIL rst_m_adr_dat: got %h/%h expected 0/0", m_adr, m_dat); end
    checks++; if (wb_ack !== 1'b0 || wb_rdat !== 32'h0) begin errors++; $display("FAIL rst_wb_out: got %b/%h expected 0/0", wb_ack, wb_rdat); end
    for (int i = 0; i < 6; i++) begin
      wb_read(offs[i], d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_reg[%h]: got %h expected 0", offs[i], d); end
    end
    wb_write(32'h04, 32'h0000_1003);
    wb_read(32'h04, d);
    checks++; if (d !== 32'h0000_1000) begin errors++; $display("FAIL base_align: got %h expected 00001000", d); end
  endtask

  task automatic test_frame();
    logic [31:0] d;
    int s;
    wait_states = 0;
    wb_write(32'h04, 32'h0000_2000);
    s = nlog;
    wb_write(32'h00, 32'h1);
    tick(4);
    cam_frame(2, 3, 8'h0A, 8'h5C);
    wait_idle(100);
    checks++; if (nlog - s !== 6) begin errors++; $display("FAIL frame_writes: got %0d expected 6", nlog - s); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (log_adr[s+i] !== 32'h2000 + 32'(4*i) || log_dat[s+i] !== 32'h0000_0A5C) begin
        errors++;
        $display("FAIL frame_wr[%0d]: got %h@%h expected 00000a5c@%h", i, log_dat[s+i], log_adr[s+i], 32'h2000 + 32'(4*i));
      end
    end
    wb_read(32'h08, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL frame_status: got %h expected 2", d); end
    wb_read(32'h0C, d);
    checks++; if (d !== 32'd6) begin errors++; $display("FAIL frame_pixcnt: got %0d expected 6", d); end
    wb_read(32'h10, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL frame_frmcnt: got %0d expected 1", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d, p;
    int s, e0;
    wait_states = 10;
    s = nlog;
    e0 = stall_err;
    wb_write(32'h00, 32'h1);
    tick(4);
    cam_frame(1, 40, 8'h03, 8'h21);
    wait_idle(300);
    wb_read(32'h08, d);
    checks++; if (d !== 32'h6) begin errors++; $display("FAIL ovf_status: got %h expected 6", d); end
    wb_read(32'h0C, p);
    checks++; if (p >= 32'd40 || p == 32'd0) begin errors++; $display("FAIL ovf_pixcnt: got %0d expected 1..39", p); end
    checks++; if (32'(nlog - s) !== p) begin errors++; $display("FAIL ovf_writes: got %0d expected %0d", nlog - s, p); end
    checks++; if (log_adr[(s + int'(p) - 1) % 256] !== 32'h2000 + (p - 1) * 4) begin errors++; $display("FAIL ovf_last_adr: got %h expected %h", log_adr[(s + int'(p) - 1) % 256], 32'h2000 + (p - 1) * 4); end
    checks++; if (log_dat[s % 256] !== 32'h0000_0321) begin errors++; $display("FAIL ovf_dat: got %h expected 00000321", log_dat[s % 256]); end
    checks++; if (stall_err !== e0) begin errors++; $display("FAIL stall_stable: got %0d changes expected 0", stall_err - e0); end
    wait_states = 0;
  endtask

  task automatic test_max_pixels();
    logic [31:0] d;
    int s;
    use_small = 1'b1;
    wait_states = 0;
    wb_write(32'h04, 32'h0000_0100);
    s = nlog;
    wb_write(32'h00, 32'h1);
    tick(4);
    cam_frame(2, 3, 8'h07, 8'h81);
    wait_idle(100);
    checks++; if (nlog - s !== 4) begin errors++; $display("FAIL max_writes: got %0d expected 4", nlog - s); end
    checks++; if (log_adr[(s + 3) % 256] !== 32'h10C || log_dat[(s + 3) % 256] !== 32'h781) begin errors++; $display("FAIL max_last_wr: got %h@%h expected 00000781@0000010c", log_dat[(s + 3) % 256], log_adr[(s + 3) % 256]); end
    wb_read(32'h0C, d);
    checks++; if (d !== 32'd4) begin errors++; $display("FAIL max_pixcnt: got %0d expected 4", d); end
    wb_read(32'h08, d);
    checks++; if (d !== 32'h6) begin errors++; $display("FAIL max_status: got %h expected 6", d); end
    wb_write(32'h08, 32'h6);
    wb_read(32'h08, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_status: got %h expected 0", d); end
    use_small = 1'b0;
  endtask

  task automatic test_continuous();
    logic [31:0] d;
    int s;
    apply_reset();
    wait_states = 0;
    wb_write(32'h04, 32'h0000_3000);
    wb_write(32'h00, 32'h3);
    wb_read(32'h00, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL cont_ctrl: got %h expected 2", d); end
    for (int f = 0; f < 3; f++) begin
      s = nlog;
      if (f < 2) begin
        cam_frame(1, 2, 8'h01, 8'h23);
      end else begin
        fork
          cam_frame(1, 2, 8'h01, 8'h23);
          begin tick(20); wb_write(32'h00, 32'h0); end
        join
      end
      tick(40);
      checks++;
      if (nlog - s !== 2 || log_adr[s % 256] !== 32'h3000 || log_adr[(s + 1) % 256] !== 32'h3004) begin
        errors++;
        $display("FAIL cont_frame%0d: got %0d writes first %h second %h expected 2 at 3000/3004", f, nlog - s, log_adr[s % 256], log_adr[(s + 1) % 256]);
      end
    end
    wait_idle(50);
    wb_read(32'h10, d);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL cont_frmcnt: got %0d expected 3", d); end
    wb_read(32'h08, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL cont_status: got %h expected 2", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int s, t;
    wait_states = 10;
    wb_write(32'h00, 32'h1);
    tick(4);
    fork
      cam_frame(1, 10, 8'h0A, 8'h5C);
      begin
        t = 0;
        while (!m_stb && t < 2000) begin tick(1); t++; end
        if (!m_stb) begin
          checks++; errors++;
          $display("FAIL mid_stb_wait: m_stb %b after %0d cycles expected 1", m_stb, t);
        end
        reset = 1'b1;
        tick(1);
        checks++; if (m_cyc !== 1'b0 || m_stb !== 1'b0) begin errors++; $display("FAIL mid_rst_drop: got cyc/stb %b%b expected 00", m_cyc, m_stb); end
        reset = 1'b0;
      end
    join
    tick(4);
    wb_read(32'h08, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_status: got %h expected 0", d); end
    wait_states = 0;
    wb_write(32'h04, 32'h0000_5000);
    s = nlog;
    wb_write(32'h00, 32'h1);
    tick(4);
    cam_frame(1, 2, 8'h0A, 8'h5C);
    wait_idle(100);
    checks++;
    if (nlog - s !== 2 || log_adr[s % 256] !== 32'h5000 || log_dat[s % 256] !== 32'hA5C) begin
      errors++;
      $display("FAIL mid_recapture: got %0d writes first %h@%h expected 2 first 00000a5c@00005000", nlog - s, log_dat[s % 256], log_adr[s % 256]);
    end
    wb_read(32'h0C, d);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL mid_pixcnt: got %0d expected 2", d); end
  endtask

  initial begin
    reset = 1'b1;
    use_small = 1'b0;
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    wb_adr = '0; wb_wdat = '0;
    cam_pclk = 1'b0; cam_vsync = 1'b1; cam_href = 1'b0; cam_data = '0;
    tick(2);
    test_reset();
    test_frame();
    test_overflow();
    test_max_pixels();
    test_continuous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
